// File: rtl/mio_responder.sv
// Memory-mapped I/O responder: decodes CPU bus accesses to RAM, LED/switch,
// counter and keyboard, inserting per-region wait states before MIO_ready.
module mio_responder #(
    parameter int unsigned RAM_WAIT = 1,
    parameter int unsigned IO_WAIT  = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        CPU_MIO,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] addr_bus,
    input  logic [31:0] Data_in,
    output logic [31:0] Data_out,
    output logic        MIO_ready,
    output logic [9:0]  ram_addr,
    output logic [31:0] ram_din,
    output logic        ram_we,
    input  logic [31:0] ram_dout,
    input  logic [7:0]  sw,
    output logic [7:0]  led_out,
    input  logic [31:0] counter_val,
    output logic        counter_we,
    output logic [31:0] counter_din,
    input  logic        kbd_ready,
    input  logic [7:0]  kbd_data,
    output logic        kbd_ack
);

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 10;
    localparam int unsigned CW = 3;
    localparam int unsigned LW = 8;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
    typedef enum logic [2:0] {T_NONE, T_RAM, T_LED, T_CNT, T_KBD} tgt_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    tgt_t          tgt_q, tgt_d;
    logic          wr_q, wr_d;
    logic [AW-1:0] word_q, word_d;
    logic [DW-1:0] data_q, data_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          ready_q, ready_d;
    logic          ram_we_q, ram_we_d;
    logic [LW-1:0] led_q, led_d;
    logic          cnt_we_q, cnt_we_d;
    logic          kbd_ack_q, kbd_ack_d;

    logic          req;
    tgt_t          tgt_in;
    logic [CW-1:0] sel_wait;
    tgt_t          cur_tgt;
    logic          cur_wr;
    logic [DW-1:0] cur_data;
    logic          unused_addr;

    assign req         = CPU_MIO & (MemRead | MemWrite);
    assign unused_addr = ^addr_bus[1:0];

    // Address decode of the live bus
    always_comb begin
        tgt_in = T_NONE;
        if (addr_bus[31:12] == 20'd0) begin
            tgt_in = T_RAM;
        end else if (addr_bus[31:28] == 4'hF) begin
            unique case (addr_bus[3:2])
                2'b00:   tgt_in = T_LED;
                2'b01:   tgt_in = T_CNT;
                2'b10:   tgt_in = T_KBD;
                default: tgt_in = T_NONE;
            endcase
        end
    end

    assign sel_wait = (tgt_in == T_RAM) ? CW'(RAM_WAIT) : CW'(IO_WAIT);

    // Zero-wait accesses complete straight from IDLE, so use the live bus there
    assign cur_tgt  = (state_q == S_IDLE) ? tgt_in   : tgt_q;
    assign cur_wr   = (state_q == S_IDLE) ? MemWrite : wr_q;
    assign cur_data = (state_q == S_IDLE) ? Data_in  : data_q;

    // RAM sees the address in the accepting cycle so its 1-cycle read lands in time
    assign ram_addr    = (state_q == S_IDLE) ? addr_bus[11:2] : word_q;
    assign ram_din     = data_q;
    assign ram_we      = ram_we_q;
    assign counter_din = data_q;
    assign Data_out    = dout_q;
    assign MIO_ready   = ready_q;
    assign led_out     = led_q;
    assign counter_we  = cnt_we_q;
    assign kbd_ack     = kbd_ack_q;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        tgt_d     = tgt_q;
        wr_d      = wr_q;
        word_d    = word_q;
        data_d    = data_q;
        dout_d    = dout_q;
        led_d     = led_q;
        ram_we_d  = 1'b0;
        cnt_we_d  = 1'b0;
        kbd_ack_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    tgt_d    = tgt_in;
                    wr_d     = MemWrite;
                    word_d   = addr_bus[11:2];
                    data_d   = Data_in;
                    ram_we_d = MemWrite & (tgt_in == T_RAM);
                    if (sel_wait == CW'(0)) begin
                        state_d = S_DONE;
                        count_d = CW'(0);
                    end else begin
                        state_d = S_WAIT;
                        count_d = sel_wait - CW'(1);
                    end
                end
            end
            S_WAIT: begin
                if (count_q == CW'(0)) begin
                    state_d = S_DONE;
                end else begin
                    count_d = count_q - CW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d == S_DONE);

        // Peripheral side effects and read capture happen on the edge into DONE
        if (state_d == S_DONE) begin
            if (cur_wr) begin
                unique case (cur_tgt)
                    T_LED:   led_d    = cur_data[LW-1:0];
                    T_CNT:   cnt_we_d = 1'b1;
                    default: ;
                endcase
            end else begin
                unique case (cur_tgt)
                    T_RAM:   dout_d = ram_dout;
                    T_LED:   dout_d = {24'd0, sw};
                    T_CNT:   dout_d = counter_val;
                    T_KBD: begin
                        dout_d    = {23'd0, kbd_ready, kbd_data};
                        kbd_ack_d = kbd_ready;
                    end
                    default: dout_d = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            tgt_q     <= T_NONE;
            wr_q      <= 1'b0;
            word_q    <= '0;
            data_q    <= '0;
            dout_q    <= '0;
            ready_q   <= 1'b0;
            ram_we_q  <= 1'b0;
            led_q     <= '0;
            cnt_we_q  <= 1'b0;
            kbd_ack_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            tgt_q     <= tgt_d;
            wr_q      <= wr_d;
            word_q    <= word_d;
            data_q    <= data_d;
            dout_q    <= dout_d;
            ready_q   <= ready_d;
            ram_we_q  <= ram_we_d;
            led_q     <= led_d;
            cnt_we_q  <= cnt_we_d;
            kbd_ack_q <= kbd_ack_d;
        end
    end

endmodule

// File: tb/tb_mio_responder.sv
// Bench for mio_responder: two instances (short and long waits) sharing the CPU
// bus, each with its own RAM model; one is held in reset while the other runs.
module tb_mio_responder;

    logic        clk;
    logic        rst1, rst3, sel3;
    logic        CPU_MIO, MemRead, MemWrite;
    logic [31:0] addr_bus, Data_in, counter_val;
    logic [7:0]  sw, kbd_data;
    logic        kbd_ready;

    logic [31:0] dout1, dout3, rdin1, rdin3, rdout1, rdout3, cdin1, cdin3;
    logic [9:0]  raddr1, raddr3;
    logic        rdy1, rdy3, rwe1, rwe3, cwe1, cwe3, ack1, ack3;
    logic [7:0]  led1, led3;

    logic [31:0] mem1 [1024];
    logic [31:0] mem3 [1024];

    mio_responder #(.RAM_WAIT(1), .IO_WAIT(0)) u_dut (
        .clk(clk), .reset(rst1), .CPU_MIO(CPU_MIO), .MemRead(MemRead), .MemWrite(MemWrite),
        .addr_bus(addr_bus), .Data_in(Data_in), .Data_out(dout1), .MIO_ready(rdy1),
        .ram_addr(raddr1), .ram_din(rdin1), .ram_we(rwe1), .ram_dout(rdout1),
        .sw(sw), .led_out(led1), .counter_val(counter_val), .counter_we(cwe1),
        .counter_din(cdin1), .kbd_ready(kbd_ready), .kbd_data(kbd_data), .kbd_ack(ack1)
    );

    mio_responder #(.RAM_WAIT(3), .IO_WAIT(2)) u_dut3 (
        .clk(clk), .reset(rst3), .CPU_MIO(CPU_MIO), .MemRead(MemRead), .MemWrite(MemWrite),
        .addr_bus(addr_bus), .Data_in(Data_in), .Data_out(dout3), .MIO_ready(rdy3),
        .ram_addr(raddr3), .ram_din(rdin3), .ram_we(rwe3), .ram_dout(rdout3),
        .sw(sw), .led_out(led3), .counter_val(counter_val), .counter_we(cwe3),
        .counter_din(cdin3), .kbd_ready(kbd_ready), .kbd_data(kbd_data), .kbd_ack(ack3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port RAMs, 1-cycle read
    always @(posedge clk) begin
        if (rwe1) mem1[raddr1] <= rdin1;
        rdout1 <= mem1[raddr1];
        if (rwe3) mem3[raddr3] <= rdin3;
        rdout3 <= mem3[raddr3];
    end

    logic [31:0] m_dout, m_rdin, m_cdin;
    logic [9:0]  m_raddr;
    logic        m_rdy, m_rwe, m_cwe, m_ack;
    logic [7:0]  m_led;
    assign m_dout  = sel3 ? dout3  : dout1;
    assign m_rdin  = sel3 ? rdin3  : rdin1;
    assign m_cdin  = sel3 ? cdin3  : cdin1;
    assign m_raddr = sel3 ? raddr3 : raddr1;
    assign m_rdy   = sel3 ? rdy3   : rdy1;
    assign m_rwe   = sel3 ? rwe3   : rwe1;
    assign m_cwe   = sel3 ? cwe3   : cwe1;
    assign m_ack   = sel3 ? ack3   : ack1;
    assign m_led   = sel3 ? led3   : led1;

    typedef struct {
        logic [1:0]  typ;   // {MemWrite, MemRead}
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [7:0]  sw;
        logic        kr;
        logic [7:0]  kd;
        logic [31:0] cval;
        logic [31:0] dout;
        int          lat;
        logic [7:0]  led;
        logic        rwe;
        logic        cwe;
        logic        ack;
    } vec_t;

    vec_t tv1 [16];
    vec_t tv3 [6];
    vec_t sb [$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic vec_t mk(logic [1:0] typ, logic [31:0] addr, logic [31:0] wdata,
                                logic [7:0] s, logic kr, logic [7:0] kd, logic [31:0] cval,
                                logic [31:0] dout, int lat, logic [7:0] led,
                                logic rwe, logic cwe, logic ack);
        vec_t v;
        v.typ = typ; v.addr = addr; v.wdata = wdata; v.sw = s; v.kr = kr; v.kd = kd;
        v.cval = cval; v.dout = dout; v.lat = lat; v.led = led;
        v.rwe = rwe; v.cwe = cwe; v.ack = ack;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_state(input string nm);
        chk({nm, " MIO_ready"},   32'(m_rdy), 32'd0);
        chk({nm, " Data_out"},    m_dout,     32'd0);
        chk({nm, " ram_we"},      32'(m_rwe), 32'd0);
        chk({nm, " led_out"},     32'(m_led), 32'd0);
        chk({nm, " counter_we"},  32'(m_cwe), 32'd0);
        chk({nm, " kbd_ack"},     32'(m_ack), 32'd0);
        chk({nm, " counter_din"}, m_cdin,     32'd0);
        chk({nm, " ram_din"},     m_rdin,     32'd0);
    endtask

    task automatic drive(input vec_t v);
        CPU_MIO = 1'b1;
        {MemWrite, MemRead} = v.typ;
        addr_bus = v.addr; Data_in = v.wdata; sw = v.sw;
        kbd_ready = v.kr; kbd_data = v.kd; counter_val = v.cval;
    endtask

    task automatic drop_req();
        CPU_MIO = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    endtask

    // One access; the expectation travels through the scoreboard until MIO_ready
    task automatic do_access(input vec_t v);
        vec_t e;
        bit   seen;
        bit   is_ram;
        is_ram = (v.addr[31:12] == 20'd0);
        @(posedge clk); #1;
        drive(v);
        sb.push_back(v);
        @(posedge clk); #1;
        drop_req();
        seen = 1'b0;
        for (int c = 1; c <= 12 && !seen; c++) begin
            @(negedge clk);
            if (c == 1 && is_ram) chk("ram_addr", 32'(m_raddr), 32'(v.addr[11:2]));
            if (c == 1 && v.rwe) chk("ram_din", m_rdin, v.wdata);
            chk("ram_we", 32'(m_rwe), (c == 1) ? 32'(v.rwe) : 32'd0);
            if (m_rdy) begin
                seen = 1'b1;
                e = sb.pop_front();
                chk("latency", 32'(c), 32'(e.lat));
                chk("Data_out", m_dout, e.dout);
                chk("led_out", 32'(m_led), 32'(e.led));
                chk("counter_we", 32'(m_cwe), 32'(e.cwe));
                chk("kbd_ack", 32'(m_ack), 32'(e.ack));
                if (e.cwe) chk("counter_din", m_cdin, e.wdata);
            end
        end
        if (!seen) begin
            n_cmp++; n_err++;
            $display("FAIL timeout: no MIO_ready for access to 0x%08h", v.addr);
            void'(sb.pop_front());
        end
        @(negedge clk);
        chk("ready_one_cycle", 32'(m_rdy), 32'd0);
    endtask

    // Reset asserted so its edge ends the at-th cycle after acceptance
    task automatic reset_mid(input vec_t v, input int at, input string nm);
        @(posedge clk); #1;
        drive(v);
        @(posedge clk); #1;
        drop_req();
        repeat (at - 1) begin @(posedge clk); #1; end
        rst3 = 1'b1;
        @(posedge clk); #1;
        rst3 = 1'b0;
        chk_reset_state(nm);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk({nm, " no ready"},  32'(m_rdy), 32'd0);
            chk({nm, " no ram_we"}, 32'(m_rwe), 32'd0);
            chk({nm, " led"},       32'(m_led), 32'd0);
        end
    endtask

    initial begin
        int pulses;
        int last;
        vec_t e;

        tv1[0]  = mk(2'b10, 32'h0000_0010, 32'hDEAD_BEEF, 8'h00, 1'b0, 8'h00, 32'h0, 32'h0000_0000, 2, 8'h00, 1'b1, 1'b0, 1'b0);
        tv1[1]  = mk(2'b01, 32'h0000_0010, 32'h0,         8'h00, 1'b0, 8'h00, 32'h0, 32'hDEAD_BEEF, 2, 8'h00, 1'b0, 1'b0, 1'b0);
        tv1[2]  = mk(2'b10, 32'hF000_0000, 32'h0000_00A5, 8'h00, 1'b0, 8'h00, 32'h0, 32'hDEAD_BEEF, 1, 8'hA5, 1'b0, 1'b0, 1'b0);
        tv1[3]  = mk(2'b01, 32'hF000_0000, 32'h0,         8'h3C, 1'b0, 8'h00, 32'h0, 32'h0000_003C, 1, 8'hA5, 1'b0, 1'b0, 1'b0);
        tv1[4]  = mk(2'b01, 32'hF000_0008, 32'h0,         8'h3C, 1'b1, 8'h1C, 32'h0, 32'h0000_011C, 1, 8'hA5, 1'b0, 1'b0, 1'b1);
        tv1[5]  = mk(2'b01, 32'hF000_0008, 32'h0,         8'h3C, 1'b0, 8'h1C, 32'h0, 32'h0000_001C, 1, 8'hA5, 1'b0, 1'b0, 1'b0);
        tv1[6]  = mk(2'b01, 32'h8000_0000, 32'h0,         8'h3C, 1'b0, 8'h00, 32'h0, 32'h0000_0000, 1, 8'hA5, 1'b0, 1'b0, 1'b0);
        tv1[7]  = mk(2'b01, 32'hF000_0004, 32'h0,         8'h3C, 1'b0, 8'h00, 32'hCAFE_F00D, 32'hCAFE_F00D, 1, 8'hA5, 1'b0, 1'b0, 1'b0);
        tv1[8]  = mk(2'b10, 32'hF000_000C, 32'h1234_5678, 8'h3C, 1'b1, 8'h00, 32'h0, 32'hCAFE_F00D, 1, 8'hA5, 1'b0, 1'b0, 1'b0);
        tv1[9]  = mk(2'b10, 32'hF000_0004, 32'h55AA_0001, 8'h3C, 1'b0, 8'h00, 32'h0, 32'hCAFE_F00D, 1, 8'hA5, 1'b0, 1'b1, 1'b0);
        tv1[10] = mk(2'b10, 32'h0000_0FFC, 32'h0102_0304, 8'h3C, 1'b0, 8'h00, 32'h0, 32'hCAFE_F00D, 2, 8'hA5, 1'b1, 1'b0, 1'b0);
        tv1[11] = mk(2'b01, 32'h0000_0FFC, 32'h0,         8'h3C, 1'b0, 8'h00, 32'h0, 32'h0102_0304, 2, 8'hA5, 1'b0, 1'b0, 1'b0);
        tv1[12] = mk(2'b10, 32'hF000_0008, 32'h0000_00FF, 8'h3C, 1'b1, 8'h1C, 32'h0, 32'h0102_0304, 1, 8'hA5, 1'b0, 1'b0, 1'b0);
        tv1[13] = mk(2'b10, 32'h0000_1000, 32'hFFFF_FFFF, 8'h3C, 1'b0, 8'h00, 32'h0, 32'h0102_0304, 1, 8'hA5, 1'b0, 1'b0, 1'b0);
        tv1[14] = mk(2'b01, 32'hF000_0000, 32'h0,         8'h81, 1'b0, 8'h00, 32'h0, 32'h0000_0081, 1, 8'hA5, 1'b0, 1'b0, 1'b0);
        tv1[15] = mk(2'b11, 32'hF000_0000, 32'h0000_005A, 8'h81, 1'b0, 8'h00, 32'h0, 32'h0000_0081, 1, 8'h5A, 1'b0, 1'b0, 1'b0);

        tv3[0]  = mk(2'b01, 32'h8000_0000, 32'h0,         8'h00, 1'b0, 8'h00, 32'h0, 32'h0000_0000, 3, 8'h00, 1'b0, 1'b0, 1'b0);
        tv3[1]  = mk(2'b10, 32'h0000_0040, 32'hA1B2_C3D4, 8'h00, 1'b0, 8'h00, 32'h0, 32'h0000_0000, 4, 8'h00, 1'b1, 1'b0, 1'b0);
        tv3[2]  = mk(2'b01, 32'h0000_0040, 32'h0,         8'h00, 1'b0, 8'h00, 32'h0, 32'hA1B2_C3D4, 4, 8'h00, 1'b0, 1'b0, 1'b0);
        tv3[3]  = mk(2'b10, 32'hF000_0000, 32'h0000_003C, 8'h00, 1'b0, 8'h00, 32'h0, 32'hA1B2_C3D4, 3, 8'h3C, 1'b0, 1'b0, 1'b0);
        tv3[4]  = mk(2'b01, 32'hF000_0004, 32'h0,         8'h00, 1'b0, 8'h00, 32'h0BAD_F00D, 32'h0BAD_F00D, 3, 8'h3C, 1'b0, 1'b0, 1'b0);
        tv3[5]  = mk(2'b01, 32'hF000_0008, 32'h0,         8'h00, 1'b1, 8'h42, 32'h0, 32'h0000_0142, 3, 8'h00, 1'b0, 1'b0, 1'b1);

        rst1 = 1'b1; rst3 = 1'b1; sel3 = 1'b0;
        CPU_MIO = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        addr_bus = '0; Data_in = '0; sw = '0; kbd_ready = 1'b0; kbd_data = '0; counter_val = '0;

        repeat (3) @(posedge clk);
        #1 rst1 = 1'b0;
        chk_reset_state("reset1");

        for (int i = 0; i < 16; i++) do_access(tv1[i]);

        // Read held on the bus across three complete accesses
        @(posedge clk); #1;
        drive(tv1[1]);
        repeat (3) sb.push_back(tv1[1]);
        pulses = 0;
        last = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (m_rdy) begin
                pulses++;
                if (sb.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL held_extra_ready: pulse %0d at cycle %0d, expected 3 pulses", pulses, c);
                end else begin
                    e = sb.pop_front();
                    chk("held Data_out", m_dout, e.dout);
                end
                if (last >= 0) chk("held gap", 32'(c - last), 32'd3);
                last = c;
                if (pulses == 3) drop_req();
            end
        end
        drop_req();
        chk("held pulses", 32'(pulses), 32'd3);
        chk("sb empty", 32'(sb.size()), 32'd0);
        sb.delete();

        // Long-wait instance
        @(posedge clk); #1;
        rst1 = 1'b1; sel3 = 1'b1;
        @(posedge clk); #1;
        rst3 = 1'b0;
        chk_reset_state("reset3");
        for (int i = 0; i < 5; i++) do_access(tv3[i]);

        reset_mid(mk(2'b10, 32'h0000_0044, 32'h0000_0099, 8'h00, 1'b0, 8'h00, 32'h0, 32'h0, 4, 8'h00, 1'b1, 1'b0, 1'b0), 2, "abort_ram");
        reset_mid(mk(2'b10, 32'hF000_0000, 32'h0000_0077, 8'h00, 1'b0, 8'h00, 32'h0, 32'h0, 3, 8'h00, 1'b0, 1'b0, 1'b0), 2, "abort_led");

        // Reset and request together: reset wins, nothing starts
        @(posedge clk); #1;
        rst3 = 1'b1;
        drive(mk(2'b10, 32'hF000_0000, 32'h0000_0066, 8'h00, 1'b0, 8'h00, 32'h0, 32'h0, 3, 8'h00, 1'b0, 1'b0, 1'b0));
        @(posedge clk); #1;
        rst3 = 1'b0;
        drop_req();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_req no ready", 32'(m_rdy), 32'd0);
            chk("rst_req led", 32'(m_led), 32'd0);
        end

        do_access(tv3[5]);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mio_responder.md
MIO_RESPONDER -- requirements
Module: mio_responder

Interface
REQ-001 Parameter RAM_WAIT, default 1, wait cycles for RAM access, legal 1..7.
REQ-002 Parameter IO_WAIT, default 0, wait cycles for peripheral access, legal 0..7.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 CPU_MIO  in  1  CPU bus request qualifier.
REQ-006 MemRead / MemWrite  in  1 each  access type.
REQ-007 addr_bus  in  32  byte address of the access.
REQ-008 Data_in  in  32  CPU write data.
REQ-009 Data_out  out  32  read data to CPU, registered.
REQ-010 MIO_ready  out  1  access-complete strobe to CPU, registered.
REQ-011 ram_addr  out  10  word address to RAM; ram_din out 32; ram_we out 1; ram_dout in 32 (synchronous RAM, 1-cycle read).
REQ-012 sw  in  8  switches; led_out  out  8  LED register.
REQ-013 counter_val  in  32; counter_we  out  1; counter_din  out  32.
REQ-014 kbd_ready  in  1; kbd_data  in  8; kbd_ack  out  1  keyboard pop strobe.

Function
REQ-015 Request = CPU_MIO & (MemRead | MemWrite); MemRead and MemWrite both high is treated as a write.
REQ-016 Decode: addr_bus[31:12]==0 is RAM, word index addr_bus[11:2]. addr_bus[31:28]==4'hF is IO, selected by addr_bus[3:2]: 00 LED/switch, 01 counter, 10 keyboard, 11 unmapped.
REQ-017 Addresses outside both regions are unmapped: reads return 0, writes are dropped, and the access still completes using IO_WAIT.
REQ-018 FSM states: IDLE, WAIT, DONE.
REQ-019 IDLE with request: latch address, data, type and region; go to WAIT with count = wait-1, or straight to DONE if the selected wait is 0.
REQ-020 IDLE without request: stay in IDLE.
REQ-021 WAIT: decrement count each cycle; go to DONE on the cycle count==0.
REQ-022 DONE: MIO_ready=1 for exactly this one cycle, then return to IDLE unconditionally.
REQ-023 A request still held in the following IDLE cycle starts a new access (back-to-back accesses allowed).
REQ-024 MIO_ready is high only in DONE; request inputs are ignored outside IDLE.
REQ-025 Latency: MIO_ready is high in cycle k+N+1, where k is the IDLE cycle that accepted the request and N is the selected wait.
REQ-026 RAM write: ram_we high for exactly the first cycle after acceptance, with ram_addr/ram_din holding the latched values; Data_out unchanged.
REQ-027 RAM read: ram_addr held from acceptance; Data_out loads ram_dout on the transition into DONE.
REQ-028 LED write: led_out <= Data_in[7:0] on entering DONE.
REQ-029 LED/switch read: Data_out = {24'b0, sw}.
REQ-030 Counter write: counter_we pulses one cycle in DONE, with counter_din = latched data.
REQ-031 Counter read: Data_out = counter_val, sampled on entering DONE.
REQ-032 Keyboard read: Data_out = {23'b0, kbd_ready, kbd_data}, sampled on entering DONE.
REQ-033 kbd_ack pulses in DONE iff the sampled kbd_ready was 1.
REQ-034 Keyboard write: no effect.
REQ-035 Data_out holds its value between reads and after writes.

Reset
REQ-036 When reset is high at a rising edge: state=IDLE, count=0, MIO_ready=0, Data_out=0, ram_we=0, led_out=0, counter_we=0, kbd_ack=0, latched address/data=0.
REQ-037 Reset mid-access aborts the access: no ram_we, no MIO_ready, and no peripheral side effect after the reset edge.
REQ-038 reset takes priority over a request in the same cycle.

Verification
REQ-039 RAM_WAIT=1: write 0xDEADBEEF to 0x00000010 -> ram_we one cycle, ram_addr=4; then read 0x00000010 -> MIO_ready in cycle k+2, Data_out=0xDEADBEEF.
REQ-040 IO_WAIT=0: write 0xA5 to 0xF0000000 -> MIO_ready at k+1, led_out=0xA5; with sw=0x3C, read 0xF0000000 -> Data_out=0x0000003C.
REQ-041 kbd_ready=1, kbd_data=0x1C, read 0xF0000008 -> Data_out=0x0000011C, kbd_ack one cycle; repeat with kbd_ready=0 -> Data_out=0x0000001C, no kbd_ack.
REQ-042 Read 0x80000000 (unmapped) -> Data_out=0, MIO_ready after IO_WAIT+1; write 0xF000000C -> no outputs change except MIO_ready.
REQ-043 RAM_WAIT=3: reset asserted in the second WAIT cycle of a write -> MIO_ready never pulses, state IDLE, all outputs at reset values.
REQ-044 Request held continuously across 3 reads -> exactly 3 MIO_ready pulses, each separated by one IDLE cycle.
